// File: rtl/pkg_check.sv
// Stream sink/checker for the PkgGen packet stream: framing checks plus throughput statistics.
// Optional LFSR-driven backpressure is enabled by defining PKG_CHECK_BACKPRESSURE_EN.
module pkg_check #(
  parameter int DATA_W    = 512,
  parameter int MAX_BEATS = 64,
  parameter int CNT_W     = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_enable,
  input  logic                  io_clear,
  input  logic                  io_data_in_valid,
  output logic                  io_data_in_ready,
  input  logic [DATA_W-1:0]     io_data_in_bits_data,
  input  logic [DATA_W/8-1:0]   io_data_in_bits_keep,
  input  logic                  io_data_in_bits_last,
  output logic [CNT_W-1:0]      io_pkt_count,
  output logic [CNT_W-1:0]      io_beat_count,
  output logic [63:0]           io_byte_count,
  output logic [CNT_W-1:0]      io_err_count,
  output logic [2:0]            io_err_code,
  output logic [15:0]           io_last_pkt_bytes,
  output logic [CNT_W-1:0]      io_active_cycles
);
  localparam int KW = DATA_W / 8;
  localparam int PW = $clog2(KW + 1);
  localparam int BW = $clog2(MAX_BEATS + 1);
  localparam logic [BW-1:0] MAX_B = BW'(MAX_BEATS);

  typedef enum logic [1:0] {IDLE, BODY, DROP} state_t;

  state_t          state;
  logic            ready_q;
  logic [BW-1:0]   beat_idx;
  logic [15:0]     pkt_bytes;
  logic            pkt_err;
  logic            active;

  logic            fire;
  logic [PW-1:0]   pop;
  logic [2:0]      beat_err;
  logic [2:0]      err_now;
  logic [BW-1:0]   beat_next;
  logic            oversize;
  logic [16:0]     pkt_sum;
  logic [15:0]     pkt_bytes_next;
  logic [64:0]     byte_sum;
  logic [KW-1:0]   keep_inc;

  // Payload is not inspected; it only exists on the port as a debug tap.
  logic unused_data;
  assign unused_data = ^io_data_in_bits_data;

  assign io_data_in_ready = ready_q;
  assign fire = io_data_in_valid & ready_q;

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < KW; i++)
      pop = pop + PW'(io_data_in_bits_keep[i]);
  end

  always_comb begin
    beat_err = '0;
    keep_inc = io_data_in_bits_keep + KW'(1);
    if (io_data_in_bits_last) begin
      beat_err[0] = (io_data_in_bits_keep & keep_inc) != '0;
      beat_err[2] = io_data_in_bits_keep == '0;
    end else begin
      beat_err[1] = io_data_in_bits_keep != '1;
    end
    beat_next = (state == IDLE) ? BW'(1) : beat_idx + BW'(1);
    oversize  = fire && !io_data_in_bits_last && (state != DROP) && (beat_next >= MAX_B);
    err_now   = beat_err | {oversize, 2'b00};
    pkt_sum        = {1'b0, pkt_bytes} + 17'(pop);
    pkt_bytes_next = pkt_sum[16] ? 16'hFFFF : pkt_sum[15:0];
    byte_sum       = {1'b0, io_byte_count} + 65'(pop);
  end

`ifdef PKG_CHECK_BACKPRESSURE_EN
  logic [15:0] lfsr;
  always_ff @(posedge clock) begin
    if (reset || io_clear) lfsr <= 16'hACE1;
    else                   lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      ready_q           <= 1'b0;
      state             <= IDLE;
      beat_idx          <= '0;
      pkt_bytes         <= '0;
      pkt_err           <= 1'b0;
      active            <= 1'b0;
      io_pkt_count      <= '0;
      io_beat_count     <= '0;
      io_byte_count     <= '0;
      io_err_count      <= '0;
      io_err_code       <= '0;
      io_last_pkt_bytes <= '0;
      io_active_cycles  <= '0;
    end else begin
`ifdef PKG_CHECK_BACKPRESSURE_EN
      ready_q <= io_enable & (lfsr[1:0] != 2'b00);
`else
      ready_q <= io_enable;
`endif
      // Clear wins over a coincident beat: that beat never reaches the statistics.
      if (io_clear) begin
        state             <= IDLE;
        beat_idx          <= '0;
        pkt_bytes         <= '0;
        pkt_err           <= 1'b0;
        active            <= 1'b0;
        io_pkt_count      <= '0;
        io_beat_count     <= '0;
        io_byte_count     <= '0;
        io_err_count      <= '0;
        io_err_code       <= '0;
        io_last_pkt_bytes <= '0;
        io_active_cycles  <= '0;
      end else begin
        if (active && io_active_cycles != '1)
          io_active_cycles <= io_active_cycles + CNT_W'(1);
        if (fire) begin
          if (!active) begin
            active           <= 1'b1;
            io_active_cycles <= CNT_W'(1);
          end
          if (io_beat_count != '1) io_beat_count <= io_beat_count + CNT_W'(1);
          io_byte_count <= byte_sum[64] ? '1 : byte_sum[63:0];
          io_err_code   <= io_err_code | err_now;
          if (io_data_in_bits_last) begin
            if (io_pkt_count != '1) io_pkt_count <= io_pkt_count + CNT_W'(1);
            if ((pkt_err || err_now != '0) && io_err_count != '1)
              io_err_count <= io_err_count + CNT_W'(1);
            io_last_pkt_bytes <= pkt_bytes_next;
            pkt_bytes <= '0;
            pkt_err   <= 1'b0;
            beat_idx  <= '0;
            state     <= IDLE;
          end else begin
            pkt_bytes <= pkt_bytes_next;
            pkt_err   <= pkt_err | (err_now != '0);
            case (state)
              IDLE, BODY: begin
                if (oversize) state <= DROP;
                else begin
                  state    <= BODY;
                  beat_idx <= beat_next;
                end
              end
              default: state <= DROP;
            endcase
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_pkg_check.sv
// Directed bench for pkg_check: reference model pushes expected packet results, compared on completion.
module tb_pkg_check;
  localparam int DATA_W    = 512;
  localparam int KW        = DATA_W / 8;
  localparam int MAX_BEATS = 64;
  localparam int CNT_W     = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic              io_enable;
  logic              io_clear;
  logic              io_data_in_valid;
  logic              io_data_in_ready;
  logic [DATA_W-1:0] io_data_in_bits_data;
  logic [KW-1:0]     io_data_in_bits_keep;
  logic              io_data_in_bits_last;
  logic [CNT_W-1:0]  io_pkt_count;
  logic [CNT_W-1:0]  io_beat_count;
  logic [63:0]       io_byte_count;
  logic [CNT_W-1:0]  io_err_count;
  logic [2:0]        io_err_code;
  logic [15:0]       io_last_pkt_bytes;
  logic [CNT_W-1:0]  io_active_cycles;

  pkg_check #(.DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .io_enable(io_enable), .io_clear(io_clear),
    .io_data_in_valid(io_data_in_valid), .io_data_in_ready(io_data_in_ready),
    .io_data_in_bits_data(io_data_in_bits_data), .io_data_in_bits_keep(io_data_in_bits_keep),
    .io_data_in_bits_last(io_data_in_bits_last), .io_pkt_count(io_pkt_count),
    .io_beat_count(io_beat_count), .io_byte_count(io_byte_count), .io_err_count(io_err_count),
    .io_err_code(io_err_code), .io_last_pkt_bytes(io_last_pkt_bytes),
    .io_active_cycles(io_active_cycles)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pkt;
    logic [31:0] beat;
    logic [63:0] bytes;
    logic [31:0] err;
    logic [2:0]  code;
    logic [15:0] lpb;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;

  logic [31:0] m_pkt, m_beat, m_err;
  logic [63:0] m_bytes;
  logic [2:0]  m_code;
  int          m_pb, m_idx;
  bit          m_perr, m_drop;

  logic [KW-1:0] full_keep = '1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    check({tag, ".pkt"},   64'(io_pkt_count),      64'(e.pkt));
    check({tag, ".beat"},  64'(io_beat_count),     64'(e.beat));
    check({tag, ".bytes"}, io_byte_count,          e.bytes);
    check({tag, ".err"},   64'(io_err_count),      64'(e.err));
    check({tag, ".code"},  64'(io_err_code),       64'(e.code));
    check({tag, ".lpb"},   64'(io_last_pkt_bytes), 64'(e.lpb));
  endtask

  task automatic model_zero();
    m_pkt = 0; m_beat = 0; m_err = 0; m_bytes = 0; m_code = 0;
    m_pb = 0; m_idx = 0; m_perr = 0; m_drop = 0;
  endtask

  task automatic model_fire(input logic [KW-1:0] keep, input bit last);
    logic [2:0]    e;
    logic [KW-1:0] kp1;
    exp_t          x;
    int            pc;
    e = 3'b000;
    kp1 = keep + 1'b1;
    pc = $countones(keep);
    m_beat++;
    m_bytes += 64'(pc);
    m_pb += pc;
    if (last) begin
      if ((keep & kp1) != 0) e[0] = 1'b1;
      if (keep == 0) e[2] = 1'b1;
    end else begin
      if (keep != full_keep) e[1] = 1'b1;
      if (!m_drop) begin
        m_idx++;
        if (m_idx >= MAX_BEATS) begin
          e[2] = 1'b1;
          m_drop = 1'b1;
        end
      end
    end
    m_code |= e;
    if (e != 0) m_perr = 1'b1;
    if (last) begin
      m_pkt++;
      if (m_perr) m_err++;
      x.pkt = m_pkt; x.beat = m_beat; x.bytes = m_bytes; x.err = m_err; x.code = m_code;
      x.lpb = (m_pb > 65535) ? 16'hFFFF : 16'(m_pb);
      exp_q.push_back(x);
      m_pb = 0; m_idx = 0; m_perr = 0; m_drop = 0;
    end
  endtask

  // Presents one beat at a negedge, waits (bounded) for ready, returns at the negedge after it fires.
  task automatic send_beat(input logic [KW-1:0] keep, input bit last, input bit clr);
    int   n;
    exp_t e;
    io_data_in_valid = 1'b1;
    io_data_in_bits_keep = keep;
    io_data_in_bits_last = last;
    io_data_in_bits_data = {16{$urandom}};
    n = 0;
    while (io_data_in_ready !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (io_data_in_ready !== 1'b1) begin
      check("ready_timeout", 64'(io_data_in_ready), 64'd1);
      io_data_in_valid = 1'b0;
      return;
    end
    io_clear = clr;
    if (clr) model_zero();
    else model_fire(keep, last);
    @(negedge clock);
    io_clear = 1'b0;
    io_data_in_valid = 1'b0;
    if (last && !clr) begin
      if (exp_q.size() == 0) check("queue_empty", 64'd0, 64'd1);
      else begin
        e = exp_q.pop_front();
        check_all("pkt_done", e);
      end
    end
  endtask

  task automatic send_pkt(input int nbeats, input logic [KW-1:0] last_keep);
    for (int i = 0; i < nbeats - 1; i++) send_beat(full_keep, 1'b0, 1'b0);
    send_beat(last_keep, 1'b1, 1'b0);
  endtask

  task automatic do_clear();
    io_clear = 1'b1;
    model_zero();
    @(negedge clock);
    io_clear = 1'b0;
  endtask

  initial begin
    logic [KW-1:0] k;
    logic [31:0]   beats_hold;
    reset = 1'b1; io_enable = 1'b1; io_clear = 1'b0; io_data_in_valid = 1'b0;
    io_data_in_bits_data = '0; io_data_in_bits_keep = '0; io_data_in_bits_last = 1'b0;
    model_zero();
    repeat (3) @(negedge clock);
    check("rst.ready",  64'(io_data_in_ready), 64'd0);
    check("rst.pkt",    64'(io_pkt_count), 64'd0);
    check("rst.bytes",  io_byte_count, 64'd0);
    check("rst.active", 64'(io_active_cycles), 64'd0);
    reset = 1'b0;
    @(negedge clock);
    check("ready_after_rst", 64'(io_data_in_ready), 64'd1);

    // Three clean 4-beat packets
    for (int p = 0; p < 3; p++) send_pkt(4, full_keep);
    check("t1.pkt",   64'(io_pkt_count), 64'd3);
    check("t1.beat",  64'(io_beat_count), 64'd12);
    check("t1.bytes", io_byte_count, 64'd768);
    check("t1.err",   64'(io_err_count), 64'd0);
    check("t1.lpb",   64'(io_last_pkt_bytes), 64'd256);

    // Single-beat partial packet after clear
    do_clear();
    check("clr.pkt",   64'(io_pkt_count), 64'd0);
    check("clr.bytes", io_byte_count, 64'd0);
    k = '0; k[3:0] = 4'hF;
    send_pkt(1, k);
    check("t2.lpb",  64'(io_last_pkt_bytes), 64'd4);
    check("t2.code", 64'(io_err_code), 64'd0);

    // Short non-last beat, then a clean packet
    k = full_keep; k[KW-1] = 1'b0;
    send_beat(k, 1'b0, 1'b0);
    send_beat(full_keep, 1'b1, 1'b0);
    check("t3.err",  64'(io_err_count), 64'd1);
    check("t3.code", 64'(io_err_code), 64'd2);
    send_pkt(2, full_keep);
    check("t3.err_clean", 64'(io_err_count), 64'd1);

    // Oversize packet followed by a clean 2-beat packet
    do_clear();
    send_pkt(MAX_BEATS + 2, full_keep);
    check("t4.err",  64'(io_err_count), 64'd1);
    check("t4.code", 64'(io_err_code), 64'd4);
    check("t4.pkt",  64'(io_pkt_count), 64'd1);
    send_pkt(2, full_keep);
    check("t4.err_clean", 64'(io_err_count), 64'd1);
    check("t4.lpb",       64'(io_last_pkt_bytes), 64'd128);

    // Exactly MAX_BEATS is still legal
    do_clear();
    send_pkt(MAX_BEATS, full_keep);
    check("max.err", 64'(io_err_count), 64'd0);

    // Keep hole and empty last beat
    do_clear();
    k = '0; k[2:0] = 3'b101;
    send_pkt(1, k);
    check("hole.code", 64'(io_err_code), 64'd1);
    send_pkt(1, '0);
    check("empty.code", 64'(io_err_code), 64'd5);
    check("empty.err",  64'(io_err_count), 64'd2);

    // Clear coincident with a mid-packet beat
    send_beat(full_keep, 1'b0, 1'b0);
    send_beat(full_keep, 1'b0, 1'b0);
    send_beat(full_keep, 1'b0, 1'b1);
    check("t5.beat",   64'(io_beat_count), 64'd0);
    check("t5.bytes",  io_byte_count, 64'd0);
    check("t5.pkt",    64'(io_pkt_count), 64'd0);
    check("t5.active", 64'(io_active_cycles), 64'd0);
    send_beat(full_keep, 1'b0, 1'b0);
    check("t5.active1", 64'(io_active_cycles), 64'd1);
    check("t5.beat1",   64'(io_beat_count), 64'd1);
    repeat (3) @(negedge clock);
    check("t5.active4", 64'(io_active_cycles), 64'd4);
    send_beat(full_keep, 1'b1, 1'b0);

    // Idle gaps between packets and an enable drop mid-packet
    do_clear();
    for (int p = 0; p < 3; p++) begin
      send_beat(full_keep, 1'b0, 1'b0);
      send_beat(full_keep, 1'b0, 1'b0);
      if (p == 1) begin
        io_enable = 1'b0;
        beats_hold = io_beat_count;
        @(negedge clock);
        check("t6.ready_low", 64'(io_data_in_ready), 64'd0);
        repeat (4) @(negedge clock);
        check("t6.beat_hold", 64'(io_beat_count), 64'(beats_hold));
        io_enable = 1'b1;
      end
      send_beat(full_keep, 1'b0, 1'b0);
      send_beat(full_keep, 1'b1, 1'b0);
      repeat (10) @(negedge clock);
    end
    check("t6.pkt",   64'(io_pkt_count), 64'd3);
    check("t6.beat",  64'(io_beat_count), 64'd12);
    check("t6.bytes", io_byte_count, 64'd768);
    check("t6.queue", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
